// File: rtl/sprite_pkg.sv
// Shared constants, FSM state encoding and sprite ROM addressing for the sprite blitter.
package sprite_pkg;

    localparam int SPR_W = 20;
    localparam int SPR_H = 40;
    localparam int FB_W  = 640;
    localparam int FB_H  = 480;

    localparam logic [3:0] TRANSP_IDX = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    // Row-major ROM address; row*SPR_W folded into shift-add for SPR_W = 20.
    function automatic logic [9:0] spr_addr(input logic [5:0] row,
                                            input logic [4:0] col,
                                            input logic       flip);
        logic [4:0] c;
        c = flip ? 5'(SPR_W - 1) - col : col;
        return (10'(row) << 4) + (10'(row) << 2) + 10'(c);
    endfunction

endpackage

// File: rtl/sprite_blitter.sv
// Copies a SPR_W x SPR_H sprite from a synchronous ROM into the framebuffer,
// one pixel per READ/WRITE pair, skipping transparent and off-screen pixels.
module sprite_blitter
    import sprite_pkg::*;
(
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        flip,
    output logic        busy,
    output logic        done,
    output logic [9:0]  rom_addr,
    input  logic [3:0]  rom_q,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [3:0]  fb_data,
    input  logic        fb_ready
);

    state_t      state;
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic        flip_q;
    logic [4:0]  col;
    logic [5:0]  row;

    logic [10:0] px;
    logic [10:0] py;
    logic        opaque;
    logic        in_bounds;
    logic        pix_we;
    logic [18:0] lin_addr;
    logic        last_col;
    logic        last_row;
    logic        advance;
    logic [4:0]  next_col;
    logic [5:0]  next_row;

    // 11-bit sums so sprites hanging past the right/bottom edge clip instead of wrapping.
    assign px        = {1'b0, x0} + 11'(col);
    assign py        = {1'b0, y0} + 11'(row);
    assign opaque    = (rom_q != TRANSP_IDX);
    assign in_bounds = (px < 11'(FB_W)) && (py < 11'(FB_H));
    assign pix_we    = (state == WRITE) && opaque && in_bounds;
    assign lin_addr  = (19'(py) << 9) + (19'(py) << 7) + 19'(px);

    assign fb_we   = pix_we;
    assign fb_addr = pix_we ? lin_addr : '0;
    assign fb_data = pix_we ? rom_q : '0;

    assign last_col = (col == 5'(SPR_W - 1));
    assign last_row = (row == 6'(SPR_H - 1));
    assign advance  = (state == WRITE) && (!pix_we || fb_ready);
    assign next_col = last_col ? 5'd0 : col + 5'd1;
    assign next_row = last_col ? row + 6'd1 : row;

    // rom_addr is loaded on every entry to READ so the ROM data lands in WRITE,
    // and it simply holds in all other states.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            x0       <= '0;
            y0       <= '0;
            flip_q   <= 1'b0;
            col      <= '0;
            row      <= '0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x0       <= pos_x;
                        y0       <= pos_y;
                        flip_q   <= flip;
                        col      <= '0;
                        row      <= '0;
                        rom_addr <= spr_addr(6'd0, 5'd0, flip);
                        busy     <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: state <= WRITE;
                WRITE: begin
                    if (advance) begin
                        col <= next_col;
                        row <= next_row;
                        if (last_col && last_row) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            rom_addr <= spr_addr(next_row, next_col, flip_q);
                            state    <= READ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: synchronous ROM model, write monitor and latency counts.
module tb_sprite_blitter;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        flip = 1'b0;
    logic        busy;
    logic        done;
    logic [9:0]  rom_addr;
    logic [3:0]  rom_q = '0;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [3:0]  fb_data;
    logic        fb_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    // monitor state
    int rom_mode = 0;
    int m_x0 = 0, m_y0 = 0, m_w = 20;
    logic m_flip = 1'b0;
    int wr_cnt, we_cyc, done_cnt, mon_err;
    int first_a, last_a, max_a, rom0, rom20;
    int cyc;

    sprite_blitter dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .start(start),
        .pos_x(pos_x), .pos_y(pos_y), .flip(flip),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_q(rom_q),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk)
        rom_q <= (rom_mode != 0) ? 4'h0 : (rom_addr[3:0] | 4'h1);

    always @(negedge vga_clk) begin
        int r, c, exp_a, exp_r;
        if (done) done_cnt++;
        if (fb_we) we_cyc++;
        if (fb_we && fb_ready) begin
            r = wr_cnt / m_w;
            c = wr_cnt % m_w;
            exp_a = (m_y0 + r) * 640 + m_x0 + c;
            exp_r = r * 20 + (m_flip ? 19 - c : c);
            if (fb_addr !== 19'(exp_a) || rom_addr !== 10'(exp_r) ||
                fb_data !== (4'(exp_r) | 4'h1))
                mon_err++;
            if (wr_cnt == 0) begin first_a = int'(fb_addr); rom0 = int'(rom_addr); end
            if (wr_cnt == 20) rom20 = int'(rom_addr);
            last_a = int'(fb_addr);
            if (int'(fb_addr) > max_a) max_a = int'(fb_addr);
            wr_cnt++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_cnt = 0; we_cyc = 0; done_cnt = 0; mon_err = 0;
        first_a = -1; last_a = -1; max_a = -1; rom0 = -1; rom20 = -1;
    endtask

    task automatic start_draw(input int x, input int y, input logic f, input int w);
        @(negedge vga_clk);
        clear_mon();
        m_x0 = x; m_y0 = y; m_flip = f; m_w = w;
        pos_x = 10'(x); pos_y = 10'(y); flip = f; start = 1'b1;
        @(posedge vga_clk);
        cyc = 1;
        @(negedge vga_clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        while (!done && cyc < 3000) begin
            @(posedge vga_clk);
            cyc++;
            @(negedge vga_clk);
        end
        chk("done_seen", int'(done), 1);
    endtask

    initial begin
        int n;
        int a0, d0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_fb_data", int'(fb_data), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;

        // plain draw at origin
        start_draw(0, 0, 1'b0, 20);
        chk("busy_after_start", int'(busy), 1);
        wait_done();
        chk("base_cycles", cyc, 1601);
        chk("base_busy_in_done", int'(busy), 0);
        @(negedge vga_clk);
        chk("base_done_1cyc", int'(done), 0);
        chk("base_writes", wr_cnt, 800);
        chk("base_first", first_a, 0);
        chk("base_last", last_a, 24979);
        chk("base_mon", mon_err, 0);
        chk("base_done_cnt", done_cnt, 1);

        // mirrored
        start_draw(0, 0, 1'b1, 20);
        chk("flip_rom_first_read", int'(rom_addr), 19);
        wait_done();
        chk("flip_cycles", cyc, 1601);
        chk("flip_rom0", rom0, 19);
        chk("flip_rom20", rom20, 39);
        chk("flip_writes", wr_cnt, 800);
        chk("flip_mon", mon_err, 0);

        // clipped at bottom-right corner
        start_draw(630, 470, 1'b0, 10);
        wait_done();
        chk("clip_cycles", cyc, 1601);
        chk("clip_writes", wr_cnt, 100);
        chk("clip_max", max_a, 479 * 640 + 639);
        chk("clip_mon", mon_err, 0);

        // fully transparent sprite
        rom_mode = 1;
        start_draw(5, 5, 1'b0, 20);
        wait_done();
        chk("transp_cycles", cyc, 1601);
        chk("transp_we", we_cyc, 0);
        rom_mode = 0;
        @(negedge vga_clk);

        // back-pressure on the first opaque pixel, start pulsed while busy
        @(posedge vga_clk);
        #1 fb_ready = 1'b0;
        start_draw(0, 0, 1'b0, 20);
        fork
            wait_done();
            begin
                n = 0;
                while (!fb_we && n < 20) begin @(negedge vga_clk); n++; end
                chk("stall_we_seen", int'(fb_we), 1);
                a0 = int'(fb_addr);
                d0 = int'(fb_data);
                for (int i = 0; i < 4; i++) begin
                    @(negedge vga_clk);
                    start = (i == 1);
                    chk("stall_addr", int'(fb_addr), a0);
                    chk("stall_data", int'(fb_data), d0);
                end
                start = 1'b0;
                @(posedge vga_clk);
                #1 fb_ready = 1'b1;
            end
        join
        chk("stall_cycles", cyc, 1606);
        chk("stall_writes", wr_cnt, 800);
        chk("stall_mon", mon_err, 0);
        repeat (4) @(negedge vga_clk);
        chk("stall_no_restart", int'(busy), 0);
        chk("stall_done_cnt", done_cnt, 1);

        // reset in the middle of a draw
        start_draw(0, 0, 1'b0, 20);
        n = 0;
        while (wr_cnt < 300 && n < 2000) begin @(negedge vga_clk); n++; end
        chk("rst_reach300", wr_cnt, 300);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_fb_we", int'(fb_we), 0);
        chk("mid_rst_fb_addr", int'(fb_addr), 0);
        chk("mid_rst_fb_data", int'(fb_data), 0);
        chk("mid_rst_rom_addr", int'(rom_addr), 0);
        repeat (3) @(negedge vga_clk);
        reset_n = 1'b1;
        repeat (3) @(negedge vga_clk);
        chk("mid_rst_no_done", done_cnt, 0);
        chk("mid_rst_idle", int'(busy), 0);
        start_draw(0, 0, 1'b0, 20);
        wait_done();
        chk("redraw_cycles", cyc, 1601);
        chk("redraw_first", first_a, 0);
        chk("redraw_rom0", rom0, 1 - 1);
        chk("redraw_writes", wr_cnt, 800);
        chk("redraw_mon", mon_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have port vga_clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: draw request, sampled only in IDLE.
REQ-004 SHALL have port pos_x, input, 10: sprite top-left column, unsigned framebuffer pixels.
REQ-005 SHALL have port pos_y, input, 10: sprite top-left row, unsigned framebuffer pixels.
REQ-006 SHALL have port flip, input, 1: 1 mirrors the sprite horizontally.
REQ-007 SHALL have port busy, output, 1: high in READ and WRITE.
REQ-008 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port rom_addr, output, 10: sprite ROM address, row-major, SPR_W per row.
REQ-010 SHALL have port rom_q, input, 4: palette index; valid in the cycle after rom_addr is presented.
REQ-011 SHALL have port fb_we, output, 1: framebuffer write request.
REQ-012 SHALL have port fb_addr, output, 19: framebuffer address = y*FB_W + x.
REQ-013 SHALL have port fb_data, output, 4: palette index to write.
REQ-014 SHALL have port fb_ready, input, 1: framebuffer accepts the write in the current cycle.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-016 IDLE with start=1: latch pos_x, pos_y, flip; set col=0, row=0; go to READ.
REQ-017 start outside IDLE SHALL be ignored; no queuing.
REQ-018 READ: rom_addr = row*SPR_W + (flip ? SPR_W-1-col : col); next state WRITE unconditionally.
REQ-019 rom_addr SHALL hold its last value outside READ.
REQ-020 WRITE: pixel is opaque when rom_q != TRANSP_IDX.
REQ-021 WRITE: pixel is in bounds when pos_x+col < FB_W and pos_y+row < FB_H; sums computed in 11 bits, no wrap.
REQ-022 WRITE: fb_we = opaque AND in bounds; fb_addr = (pos_y+row)*FB_W + (pos_x+col); fb_data = rom_q.
REQ-023 fb_we, fb_addr and fb_data SHALL be 0 outside WRITE or when fb_we=0.
REQ-024 Handshake: if fb_we=1 and fb_ready=0, stay in WRITE with fb_addr and fb_data stable.
REQ-025 A write SHALL complete in the cycle where fb_we=1 and fb_ready=1.
REQ-026 Transparent or clipped pixels SHALL advance without waiting on fb_ready.
REQ-027 On advance, increment col; at col=SPR_W-1, wrap col to 0 and increment row.
REQ-028 Advancing from col=SPR_W-1, row=SPR_H-1 SHALL go to DONE; otherwise to READ.
REQ-029 DONE: done=1 and busy=0 for exactly one cycle; then IDLE. A start in DONE is ignored.
REQ-030 Throughput: 2 cycles per pixel with fb_ready=1.
REQ-031 Latency: start accepted at edge k SHALL give done high in the cycle after edge k+SPR_W*SPR_H*2 (k+1600 for 20x40), plus one cycle per fb_ready=0 stall.

Reset
REQ-032 reset_n=0 SHALL asynchronously force state IDLE; col, row, latched position and flip to 0.
REQ-033 During reset, busy, done, fb_we, fb_addr, fb_data and rom_addr SHALL be 0.
REQ-034 Reset mid-draw SHALL abandon the draw with no done pulse; pixels already written remain.

Structure
REQ-035 Package sprite_pkg SHALL hold SPR_W=20, SPR_H=40, FB_W=640, FB_H=480, TRANSP_IDX=4'h0 and the FSM state enum.
REQ-036 Multiply by FB_W SHALL be shift-add ((y<<9)+(y<<7)); no sub-module; single flat module.

Verification
REQ-037 Sprite at pos (0,0), flip=0, fb_ready=1, all-opaque ROM (rom_q=addr[3:0]|1) -> 800 writes, first fb_addr=0, last fb_addr=39*640+19=24979; done exactly 1601 cycles after start.
REQ-038 Same setup with flip=1 -> first pixel READ cycle shows rom_addr=19; pixel col 0 row 1 uses rom_addr=39.
REQ-039 pos=(630,470) -> only columns 0-9 of rows 0-9 written (100 writes, max fb_addr=479*640+639); done still at 1601 cycles.
REQ-040 ROM all TRANSP_IDX -> zero fb_we pulses; done at 1601 cycles.
REQ-041 fb_ready held 0 for 5 cycles on the first opaque pixel -> fb_addr and fb_data stable throughout; done delayed by 5 cycles; start pulsed while busy is ignored.
REQ-042 reset_n asserted at pixel 300 -> all outputs 0 immediately; no done; next start redraws from col 0, row 0.
